anita_programmable_phi_trigger_map: RTL and testbench

Parametrised successor to the fixed SURF-L1-to-phi trigger mapping.
- Each V/H-pol phi output selects its source L1 bit from a runtime-writable map table instead of hard-wired assigns.
- Each output has a mask and a programmable pulse stretch.
- Sits between the SURF L1 inputs and the TURF phi-sector coincidence logic, in the clk250 domain.

---
 rtl/anita_programmable_phi_trigger_map.sv | 106 ++++++++++
 tb/tb_anita_programmable_phi_trigger_map.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anita_programmable_phi_trigger_map.sv
// Programmable SURF L1 to phi-sector trigger map.
// Each V/H-pol phi output picks its source L1 bit from a runtime-writable
// table. The selected bit is masked, registered, and then held high for a
// programmable number of extra cycles before it drives the output flop.
module anita_programmable_phi_trigger_map #(
    parameter int NUM_SURFS = 12,
    parameter int NUM_TRIG  = 4,
    parameter int NUM_PHI   = 16,
    parameter int SEL_W     = 6,
    parameter int ADDR_W    = 5,
    parameter int STRETCH_W = 3
) (
    input  logic                           clk250_i,
    input  logic                           rst_n_i,
    input  logic [NUM_SURFS*NUM_TRIG-1:0]  L1_i,
    input  logic [2*NUM_PHI-1:0]           mask_i,
    input  logic [STRETCH_W-1:0]           stretch_i,
    input  logic                           map_wr_i,
    input  logic [ADDR_W-1:0]              map_addr_i,
    input  logic [SEL_W-1:0]               map_data_i,
    output logic [SEL_W-1:0]               map_rd_data_o,
    output logic [NUM_PHI-1:0]             V_pol_phi_o,
    output logic [NUM_PHI-1:0]             H_pol_phi_o
);

    localparam int NL1     = NUM_SURFS * NUM_TRIG;
    localparam int NUM_OUT = 2 * NUM_PHI;

    // All-ones is the "unconnected" selector: it is >= NL1 and so never matches
    logic [SEL_W-1:0]     map_reg [NUM_OUT];
    logic [STRETCH_W-1:0] cnt_reg [NUM_OUT];
    logic [NUM_OUT-1:0]   src_bit;
    logic [NUM_OUT-1:0]   sel_reg;
    logic [NUM_OUT-1:0]   out_reg;
    logic [SEL_W-1:0]     rd_next;
    logic [SEL_W-1:0]     rd_reg;

    // Map table: an out-of-range address matches no entry, so the write is dropped
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NUM_OUT; k++) map_reg[k] <= '1;
        end else if (map_wr_i) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (map_addr_i == ADDR_W'(k)) map_reg[k] <= map_data_i;
            end
        end
    end

    // Readback mux: an unmatched address returns zero
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (map_addr_i == ADDR_W'(k)) rd_next = map_reg[k];
        end
    end

    // Readback register, one cycle behind the address
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_reg <= '0;
        else          rd_reg <= rd_next;
    end

    // Per-output source selection; selectors at or beyond NL1 give a constant 0
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_src
        logic src;
        // Compare-and-pick mux over the L1 bus so an out-of-range selector is safe
        always_comb begin
            src = 1'b0;
            for (int b = 0; b < NL1; b++) begin
                if (map_reg[gi] == SEL_W'(b)) src = L1_i[b];
            end
        end
        assign src_bit[gi] = src;
    end

    // Stage 1: masked, registered trigger selection
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) sel_reg <= '0;
        else          sel_reg <= src_bit & ~mask_i;
    end

    // Stage 2: pulse stretcher; a new hit reloads the counter, mask only gates reloads
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_reg <= '0;
            for (int k = 0; k < NUM_OUT; k++) cnt_reg[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (sel_reg[k]) begin
                    out_reg[k] <= 1'b1;
                    cnt_reg[k] <= stretch_i;
                end else if (cnt_reg[k] != '0) begin
                    out_reg[k] <= 1'b1;
                    cnt_reg[k] <= cnt_reg[k] - STRETCH_W'(1);
                end else begin
                    out_reg[k] <= 1'b0;
                end
            end
        end
    end

    assign map_rd_data_o = rd_reg;
    assign V_pol_phi_o   = out_reg[0 +: NUM_PHI];
    assign H_pol_phi_o   = out_reg[NUM_PHI +: NUM_PHI];

endmodule

// File: tb/tb_anita_programmable_phi_trigger_map.sv
// Directed bench for the programmable phi trigger map.
// Built with a 6-bit map address so that out-of-range addresses are representable.
`timescale 1ns/1ps
module tb_anita_programmable_phi_trigger_map;

    localparam int NUM_SURFS = 12;
    localparam int NUM_TRIG  = 4;
    localparam int NUM_PHI   = 16;
    localparam int SEL_W     = 6;
    localparam int ADDR_W    = 6;
    localparam int STRETCH_W = 3;
    localparam int NL1       = NUM_SURFS * NUM_TRIG;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NL1-1:0]       l1;
    logic [2*NUM_PHI-1:0] mask;
    logic [STRETCH_W-1:0] stretch;
    logic                 map_wr;
    logic [ADDR_W-1:0]    map_addr;
    logic [SEL_W-1:0]     map_data;
    logic [SEL_W-1:0]     rd_data;
    logic [NUM_PHI-1:0]   v_phi;
    logic [NUM_PHI-1:0]   h_phi;

    int vectors    = 0;
    int miscompares = 0;

    anita_programmable_phi_trigger_map #(
        .NUM_SURFS(NUM_SURFS), .NUM_TRIG(NUM_TRIG), .NUM_PHI(NUM_PHI),
        .SEL_W(SEL_W), .ADDR_W(ADDR_W), .STRETCH_W(STRETCH_W)
    ) dut (
        .clk250_i     (clk),
        .rst_n_i      (rst_n),
        .L1_i         (l1),
        .mask_i       (mask),
        .stretch_i    (stretch),
        .map_wr_i     (map_wr),
        .map_addr_i   (map_addr),
        .map_data_i   (map_data),
        .map_rd_data_o(rd_data),
        .V_pol_phi_o  (v_phi),
        .H_pol_phi_o  (h_phi)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_map(input int addr, input int data);
        map_wr   = 1'b1;
        map_addr = ADDR_W'(addr);
        map_data = SEL_W'(data);
        tick();
        map_wr   = 1'b0;
    endtask

    // Drive src with the hit pattern (bit i = high during cycle i) and measure
    // how many cycles output outk is high and on which cycle it first rises.
    task automatic run_pattern(input int src, input int outk, input logic [15:0] hits,
                               output int high_cnt, output int first);
        logic [2*NUM_PHI-1:0] outs;
        high_cnt = 0;
        first    = -1;
        for (int i = 0; i < 16; i++) begin
            l1 = '0;
            if (hits[i]) l1[src] = 1'b1;
            tick();
            outs = {h_phi, v_phi};
            if (outs[outk]) begin
                high_cnt++;
                if (first < 0) first = i;
            end
        end
        l1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; l1 = '1; mask = '0; stretch = '0;
        map_wr = 1'b0; map_addr = '0; map_data = '0;
        tick(); tick();
        vectors++;
        if (v_phi !== '0 || h_phi !== '0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: v=%h h=%h rd=%h, required all 0", v_phi, h_phi, rd_data);
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (v_phi !== '0 || h_phi !== '0) begin
            miscompares++;
            $display("FAIL unconnected_outputs: v=%h h=%h, required 0", v_phi, h_phi);
        end
        l1 = '0;
        for (int a = 0; a < 2*NUM_PHI; a++) begin
            map_addr = ADDR_W'(a);
            tick();
            vectors++;
            if (rd_data !== 6'h3F) begin
                miscompares++;
                $display("FAIL reset_readback[%0d]: got %h, required 3f", a, rd_data);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_route();
        write_map(0, 8);
        write_map(16, 10);
        l1 = '0; l1[8] = 1'b1;
        tick();
        l1 = '0;
        vectors++;
        if (v_phi !== '0 || h_phi !== '0) begin
            miscompares++;
            $display("FAIL route_v_latency1: v=%h h=%h, required 0", v_phi, h_phi);
        end
        tick();
        vectors++;
        if (v_phi !== 16'h0001 || h_phi !== 16'h0000) begin
            miscompares++;
            $display("FAIL route_v: v=%h h=%h, required v=0001 h=0000", v_phi, h_phi);
        end
        tick();
        vectors++;
        if (v_phi !== '0 || h_phi !== '0) begin
            miscompares++;
            $display("FAIL route_v_fall: v=%h h=%h, required 0", v_phi, h_phi);
        end
        l1[10] = 1'b1;
        tick();
        l1 = '0;
        tick();
        vectors++;
        if (v_phi !== 16'h0000 || h_phi !== 16'h0001) begin
            miscompares++;
            $display("FAIL route_h: v=%h h=%h, required v=0000 h=0001", v_phi, h_phi);
        end
        // Fan-out: H output 1 also follows L1 bit 8
        write_map(17, 8);
        l1[8] = 1'b1;
        tick();
        l1 = '0;
        tick();
        vectors++;
        if (v_phi !== 16'h0001 || h_phi !== 16'h0002) begin
            miscompares++;
            $display("FAIL fanout: v=%h h=%h, required v=0001 h=0002", v_phi, h_phi);
        end
        tick(); tick();
        $display("test_route done");
    endtask

    task automatic test_stretch();
        int cnt, first;
        stretch = 3'd3;
        write_map(5, 20);
        run_pattern(20, 5, 16'h0001, cnt, first);
        vectors++;
        if (cnt !== 4 || first !== 1) begin
            miscompares++;
            $display("FAIL stretch_single: high=%0d first=%0d, required high=4 first=1", cnt, first);
        end
        run_pattern(20, 5, 16'h0005, cnt, first);
        vectors++;
        if (cnt !== 6 || first !== 1) begin
            miscompares++;
            $display("FAIL stretch_retrigger: high=%0d first=%0d, required high=6 first=1", cnt, first);
        end
        run_pattern(20, 5, 16'h0007, cnt, first);
        vectors++;
        if (cnt !== 6) begin
            miscompares++;
            $display("FAIL stretch_run3: high=%0d, required 6", cnt);
        end
        $display("test_stretch done");
    endtask

    task automatic test_mask();
        int cnt, first;
        mask = '0; mask[5] = 1'b1;
        run_pattern(20, 5, 16'h0001, cnt, first);
        vectors++;
        if (cnt !== 0) begin
            miscompares++;
            $display("FAIL mask_block: high=%0d, required 0", cnt);
        end
        mask = '0;
        run_pattern(20, 5, 16'h0001, cnt, first);
        vectors++;
        if (cnt !== 4 || first !== 1) begin
            miscompares++;
            $display("FAIL mask_clear: high=%0d first=%0d, required high=4 first=1", cnt, first);
        end
        $display("test_mask done");
    endtask

    task automatic test_out_of_range();
        int cnt, first;
        write_map(32, 0);
        map_addr = 6'd32;
        tick();
        vectors++;
        if (rd_data !== 6'h00) begin
            miscompares++;
            $display("FAIL oor_readback: got %h, required 00", rd_data);
        end
        map_addr = 6'd0;
        tick();
        vectors++;
        if (rd_data !== 6'd8) begin
            miscompares++;
            $display("FAIL oor_entry0_intact: got %h, required 08", rd_data);
        end
        map_addr = 6'd3;
        tick();
        vectors++;
        if (rd_data !== 6'h3F) begin
            miscompares++;
            $display("FAIL oor_entry3_intact: got %h, required 3f", rd_data);
        end
        // Readback shows old contents on the write edge, new contents one edge later
        write_map(3, 47);
        vectors++;
        if (rd_data !== 6'h3F) begin
            miscompares++;
            $display("FAIL write_cycle_readback: got %h, required 3f", rd_data);
        end
        tick();
        vectors++;
        if (rd_data !== 6'd47) begin
            miscompares++;
            $display("FAIL post_write_readback: got %h, required 2f", rd_data);
        end
        stretch = 3'd0;
        run_pattern(47, 3, 16'h0001, cnt, first);
        vectors++;
        if (cnt !== 1 || first !== 1) begin
            miscompares++;
            $display("FAIL top_bit_route: high=%0d first=%0d, required high=1 first=1", cnt, first);
        end
        write_map(3, 48);
        l1 = '1;
        tick(); tick(); tick();
        vectors++;
        if (v_phi[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL entry48_zero: v[3]=%b, required 0", v_phi[3]);
        end
        l1 = '0;
        tick(); tick(); tick();
        $display("test_out_of_range done");
    endtask

    task automatic test_reset_mid();
        stretch = 3'd7;
        l1 = '0; l1[20] = 1'b1;
        tick();
        l1 = '0;
        tick(); tick(); tick();
        vectors++;
        if (v_phi[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_stretch_high: v[5]=%b, required 1", v_phi[5]);
        end
        map_addr = 6'd5;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (v_phi !== '0 || h_phi !== '0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset: v=%h h=%h rd=%h, required all 0", v_phi, h_phi, rd_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (rd_data !== 6'h3F || v_phi !== '0) begin
            miscompares++;
            $display("FAIL post_reset_map: rd=%h v=%h, required rd=3f v=0000", rd_data, v_phi);
        end
        map_addr = 6'd0;
        tick();
        vectors++;
        if (rd_data !== 6'h3F) begin
            miscompares++;
            $display("FAIL post_reset_map0: rd=%h, required 3f", rd_data);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_route();
        test_stretch();
        test_mask();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
